debug_uart_tx: RTL and testbench

Serial transmitter for the CPU debug ports. On a `start` request it snapshots the seven 8-bit `debug_port` buses and sends them to the host serial-port debugger as one framed UART 8N1 packet on `tx`. The packet is a sync byte, the seven data bytes, and an XOR checksum. The block sits beside `cpu` at the top level: `cpu`'s `debug_port1..7` outputs feed it, and `tx` drives the board's serial pin.

---
 rtl/debug_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_debug_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Purpose : snapshots the seven CPU debug bytes and sends them as one UART 8N1 frame:
//           sync byte, debug_port1..7, then the XOR of the seven payload bytes.
// Latency : tx drops to the start bit the cycle after start is accepted; busy lasts 90*CLKS_PER_BIT cycles.
// Backpr. : none; start is taken only while idle (including the done cycle) and is dropped, not queued, while busy.
//
// Ports:
//   clk                      - single clock, rising edge
//   nreset                   - synchronous reset, active HIGH despite the name
//   start                    - frame request, sampled every cycle
//   debug_port1..7 [7:0]     - payload bytes, captured when start is accepted
//   tx                       - serial line, idle high (registered)
//   busy                     - frame in flight (registered)
//   done                     - one-cycle pulse after the last stop bit (registered)

module debug_uart_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int            CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [7:0]    snap [1:7];
  logic [7:0]    chk;
  logic [7:0]    cur_byte;
  logic          bit_end;

  // Checksum is taken from the snapshot, so bus changes mid-frame cannot leak in.
  always_comb begin
    chk = snap[1] ^ snap[2] ^ snap[3] ^ snap[4] ^ snap[5] ^ snap[6] ^ snap[7];
  end

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = snap[1];
      4'd2:    cur_byte = snap[2];
      4'd3:    cur_byte = snap[3];
      4'd4:    cur_byte = snap[4];
      4'd5:    cur_byte = snap[5];
      4'd6:    cur_byte = snap[6];
      4'd7:    cur_byte = snap[7];
      4'd8:    cur_byte = chk;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign bit_end = (bit_cnt == CNT_MAX);

  // tx is loaded with the value of the *next* bit on the edge that ends the
  // current one, so the line stays registered and each bit lasts exactly
  // CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 1; i <= 7; i++) begin
        snap[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            snap[1]  <= debug_port1;
            snap[2]  <= debug_port2;
            snap[3]  <= debug_port3;
            snap[4]  <= debug_port4;
            snap[5]  <= debug_port5;
            snap[6]  <= debug_port6;
            snap[7]  <= debug_port7;
            byte_idx <= '0;
            bit_idx  <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START_BIT;
          end
        end

        START_BIT: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP_BIT: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx < 4'd8) begin
              byte_idx <= byte_idx + 4'd1;
              tx       <= 1'b0;
              state    <= START_BIT;
            end else begin
              // Frame complete: the done cycle is spent in IDLE, so a start
              // seen now launches the next frame on the following edge.
              byte_idx <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
module tb_debug_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 90 * CPB;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dp [1:7];
  logic       tx, busy, done;

  debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .nreset(nreset),
    .start(start),
    .debug_port1(dp[1]),
    .debug_port2(dp[2]),
    .debug_port3(dp[3]),
    .debug_port4(dp[4]),
    .debug_port5(dp[5]),
    .debug_port6(dp[6]),
    .debug_port7(dp[7]),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- UART decoder / scoreboard consumer ----------------
  bit         mon_act = 1'b0;
  int         mon_n = 0;
  int         byte_no = 0;
  logic [7:0] mon_sh = '0;
  logic [7:0] mon_exp = '0;

  always @(negedge clk) begin
    if (nreset) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx == 1'b0) begin
        mon_act = 1'b1;
        mon_n   = 0;
      end
    end else begin
      mon_n++;
      for (int k = 0; k < 8; k++) begin
        if (mon_n == CPB * (k + 1) + CPB / 2) mon_sh[k] = tx;
      end
      if (mon_n == CPB * 9 + CPB / 2) begin
        mon_act = 1'b0;
        check_eq($sformatf("stop_bit%0d", byte_no), 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", {24'h0, mon_sh}, 32'h100);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq($sformatf("byte%0d", byte_no), {24'h0, mon_sh}, {24'h0, mon_exp});
        end
        byte_no++;
      end
    end
  end

  // ---------------- output activity tracker ----------------
  int   cyc = 0, busy_run = 0, last_busy_len = 0, done_cnt = 0, frames = 0;
  int   hi_run = 0, last_hi_run = 0;
  int   done_cyc [$];
  logic p_busy = 1'b0, p_tx = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (busy === 1'b1) begin
      busy_run++;
      if (!p_busy) frames++;
    end else if (p_busy) begin
      last_busy_len = busy_run;
      busy_run      = 0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (tx === 1'b1) begin
      hi_run++;
    end else begin
      if (p_tx) last_hi_run = hi_run;
      hi_run = 0;
    end
    p_busy = (busy === 1'b1);
    p_tx   = (tx === 1'b1);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ports(input logic [7:0] b1, input logic [7:0] step);
    for (int i = 1; i <= 7; i++) dp[i] = b1 + step * 8'(i - 1);
  endtask

  task automatic push_frame();
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 1; i <= 7; i++) begin
      exp_q.push_back(dp[i]);
      x = x ^ dp[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(done === 1'b1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0, f0, dc0, n;

  initial begin
    set_ports(8'h00, 8'h00);
    nreset = 1'b1;
    start  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_eq("reset_out", {29'h0, tx, busy, done}, 32'b100);
    tick();
    nreset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("idle_out", {29'h0, tx, busy, done}, 32'b100);
    end
    check_eq("idle_no_frames", 32'(frames), 32'd0);

    // Basic frame 01..07, checksum 00
    tick();
    set_ports(8'h01, 8'h01);
    push_frame();
    d0    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_lat", {30'h0, tx, busy}, 32'b01);
    wait_done("basic_done", FRAME_CYC + 40);
    tick();
    check_eq("basic_busy_len", 32'(last_busy_len), 32'(FRAME_CYC));
    check_eq("basic_tx_in_done", 32'(tx), 32'd1);
    repeat (5) tick();
    check_eq("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("basic_sb_drain", 32'(exp_q.size()), 32'd0);

    // Snapshot: ports change the cycle after start, frame must carry FF
    set_ports(8'hFF, 8'h00);
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    set_ports(8'h00, 8'h00);
    wait_done("snap_done", FRAME_CYC + 40);
    tick();
    check_eq("snap_sb_drain", 32'(exp_q.size()), 32'd0);

    // Second start at cycle ~100 of a frame is ignored
    tick();
    set_ports(8'h11, 8'h11);
    push_frame();
    d0    = done_cnt;
    f0    = frames;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_done", FRAME_CYC + 40);
    repeat (FRAME_CYC + 40) tick();
    check_eq("ign_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("ign_frames", 32'(frames - f0), 32'd1);
    check_eq("ign_busy_len", 32'(last_busy_len), 32'(FRAME_CYC));
    check_eq("ign_sb_drain", 32'(exp_q.size()), 32'd0);

    // Back-to-back with start held high
    set_ports(8'h01, 8'h01);
    push_frame();
    push_frame();
    d0    = done_cnt;
    f0    = frames;
    dc0   = done_cyc.size();
    start = 1'b1;
    tick();
    wait_done("b2b_done1", FRAME_CYC + 40);
    n = 0;
    while (tx !== 1'b0 && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check_eq("b2b_restart", 32'(tx), 32'd0);
    tick();
    start = 1'b0;
    check_eq("b2b_gap", 32'(last_hi_run), 32'(CPB + 1));
    wait_done("b2b_done2", FRAME_CYC + 40);
    repeat (FRAME_CYC + 40) tick();
    check_eq("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
    check_eq("b2b_frames", 32'(frames - f0), 32'd2);
    if (done_cyc.size() >= dc0 + 2)
      check_eq("b2b_done_gap", 32'(done_cyc[dc0 + 1] - done_cyc[dc0]), 32'(FRAME_CYC + 1));
    else
      check_eq("b2b_done_pulses", 32'(done_cyc.size() - dc0), 32'd2);
    check_eq("b2b_sb_drain", 32'(exp_q.size()), 32'd0);

    // Reset during the start bit of byte 3
    dp[1] = 8'h3C; dp[2] = 8'h5A; dp[3] = 8'h96; dp[4] = 8'hC3;
    dp[5] = 8'h0F; dp[6] = 8'hF0; dp[7] = 8'h81;
    push_frame();
    d0    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (121) tick();
    check_eq("mid_tx_low", 32'(tx), 32'd0);
    nreset = 1'b1;
    tick();
    nreset = 1'b0;
    check_eq("mid_sb_partial", 32'(exp_q.size()), 32'd6);
    exp_q.delete();
    @(negedge clk);
    check_eq("mid_rst_out", {30'h0, tx, busy}, 32'b10);
    repeat (FRAME_CYC) tick();
    check_eq("mid_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("mid_quiet", 32'(exp_q.size()), 32'd0);

    set_ports(8'h80, 8'h03);
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("post_rst_done", FRAME_CYC + 40);
    tick();
    check_eq("post_rst_busy_len", 32'(last_busy_len), 32'(FRAME_CYC));
    check_eq("post_rst_sb_drain", 32'(exp_q.size()), 32'd0);
    check_eq("post_rst_done_cnt", 32'(done_cnt - d0), 32'd1);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
